// File: rtl/mdarr_pkg.sv
// Shared types and helpers for the multi-channel round-robin mux.
//   arb_mode_t  : arbitration policy select (ARB_RR / ARB_FIXED)
//   clog2_min1  : ceil(log2(n)) clamped to at least 1, for index widths
package mdarr_pkg;

  typedef enum bit {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_t;

  // Index width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage : mdarr_pkg

// File: rtl/mdarr_chan_fifo.sv
// Single-channel FIFO holding [AUM-1:0][BUM-1:0] words.
//   clk, rst_n : clock, synchronous active-low reset (pointers/level only)
//   flush      : synchronous clear of pointers and level
//   push       : write push_data (ignored when full)
//   pop        : drop head word (ignored when empty)
//   head_data  : word at the read pointer
//   level      : current occupancy, 0..DEPTH
//   full       : level == DEPTH
module mdarr_chan_fifo
  import mdarr_pkg::*;
#(
  parameter int unsigned AUM   = 8,
  parameter int unsigned BUM   = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           push,
  input  logic [AUM-1:0][BUM-1:0]        push_data,
  input  logic                           pop,
  output logic [AUM-1:0][BUM-1:0]        head_data,
  output logic [$clog2(DEPTH+1)-1:0]     level,
  output logic                           full
);

  localparam int unsigned PTR_W = clog2_min1(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic [AUM-1:0][BUM-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push;
  logic             do_pop;

  assign full      = (level_q == LVL_W'(DEPTH));
  assign level     = level_q;
  assign head_data = mem[rd_ptr_q];
  assign do_push   = push && !full;
  assign do_pop    = pop && (level_q != '0);

  // Pointer/level next state; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset; stale words are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && do_push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

endmodule : mdarr_chan_fifo

// File: rtl/mdarr_rr_mux.sv
// VUM-channel buffered mux with round-robin or fixed-priority arbitration.
//   clk, rst_n : clock, synchronous active-low reset
//   flush      : clears all channel FIFOs, grant lock and rr pointer
//   mode       : ARB_RR or ARB_FIXED
//   chan_en    : per-channel arbitration enable
//   in_valid / in_ready / in_data : per-channel push interface
//   out_valid / out_ready / out_data / out_chan : granted word and its channel
//   level      : per-channel occupancy
module mdarr_rr_mux
  import mdarr_pkg::*;
#(
  parameter int unsigned AUM   = 8,
  parameter int unsigned BUM   = 4,
  parameter int unsigned VUM   = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  arb_mode_t                      mode,
  input  logic [VUM-1:0]                 chan_en,
  input  logic [VUM-1:0]                 in_valid,
  output logic [VUM-1:0]                 in_ready,
  input  logic [AUM-1:0][BUM-1:0]        in_data [VUM],
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [AUM-1:0][BUM-1:0]        out_data,
  output logic [$clog2(VUM)-1:0]         out_chan,
  output logic [$clog2(DEPTH+1)-1:0]     level [VUM]
);

  localparam int unsigned CHAN_W = $clog2(VUM);
  localparam int unsigned LVL_W  = $clog2(DEPTH + 1);

  logic [VUM-1:0]          full;
  logic [VUM-1:0]          eligible;
  logic [VUM-1:0]          push_vec;
  logic [VUM-1:0]          pop_vec;
  logic [AUM-1:0][BUM-1:0] head [VUM];

  logic [CHAN_W-1:0] rr_ptr_q, rr_ptr_d;
  logic              lock_q, lock_d;
  logic [CHAN_W-1:0] lock_chan_q, lock_chan_d;

  logic [CHAN_W-1:0] arb_base;
  logic [CHAN_W-1:0] arb_chan;
  logic              arb_found;
  logic [CHAN_W-1:0] grant_chan;
  logic              pop_fire;

  assign in_ready = ~full & {VUM{~flush}};
  assign push_vec = in_valid & in_ready;

  // One FIFO per channel.
  for (genvar g = 0; g < VUM; g++) begin : g_chan
    assign eligible[g] = (level[g] != LVL_W'(0)) && chan_en[g];

    mdarr_chan_fifo #(
      .AUM   (AUM),
      .BUM   (BUM),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .push      (push_vec[g]),
      .push_data (in_data[g]),
      .pop       (pop_vec[g]),
      .head_data (head[g]),
      .level     (level[g]),
      .full      (full[g])
    );
  end

  // Search upward from the base with wrap; fixed priority is a search from 0.
  always_comb begin
    int unsigned idx;
    arb_found = 1'b0;
    arb_chan  = '0;
    arb_base  = (mode == ARB_FIXED) ? '0 : rr_ptr_q;
    for (int unsigned i = 0; i < VUM; i++) begin
      idx = 32'(arb_base) + i;
      if (idx >= VUM) idx = idx - VUM;
      if (!arb_found && eligible[CHAN_W'(idx)]) begin
        arb_found = 1'b1;
        arb_chan  = CHAN_W'(idx);
      end
    end
  end

  // A held grant overrides live arbitration so a stalled word stays put.
  assign grant_chan = lock_q ? lock_chan_q : arb_chan;
  assign out_valid  = lock_q || arb_found;
  assign out_chan   = out_valid ? grant_chan : '0;
  assign out_data   = out_valid ? head[grant_chan] : '0;
  assign pop_fire   = out_valid && out_ready && !flush;

  always_comb begin
    pop_vec = '0;
    for (int unsigned c = 0; c < VUM; c++) begin
      pop_vec[c] = pop_fire && (grant_chan == CHAN_W'(c));
    end
  end

  // Grant lock and round-robin pointer next state.
  always_comb begin
    lock_d      = lock_q;
    lock_chan_d = lock_chan_q;
    rr_ptr_d    = rr_ptr_q;
    if (flush) begin
      lock_d      = 1'b0;
      lock_chan_d = '0;
      rr_ptr_d    = '0;
    end else if (out_valid && !out_ready) begin
      lock_d      = 1'b1;
      lock_chan_d = grant_chan;
    end else if (pop_fire) begin
      lock_d   = 1'b0;
      rr_ptr_d = (grant_chan == CHAN_W'(VUM - 1)) ? '0 : grant_chan + CHAN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_q      <= 1'b0;
      lock_chan_q <= '0;
      rr_ptr_q    <= '0;
    end else begin
      lock_q      <= lock_d;
      lock_chan_q <= lock_chan_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

endmodule : mdarr_rr_mux

// File: tb/tb_mdarr_rr_mux.sv
// Directed bench for mdarr_rr_mux with default parameters (8x4 words, 4 channels, depth 4).
module tb_mdarr_rr_mux;
  import mdarr_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  arb_mode_t       mode;
  logic [3:0]      chan_en;
  logic [3:0]      in_valid;
  logic [3:0]      in_ready;
  logic [7:0][3:0] in_data [4];
  logic            out_valid;
  logic            out_ready;
  logic [7:0][3:0] out_data;
  logic [1:0]      out_chan;
  logic [2:0]      level [4];

  int checks   = 0;
  int failures = 0;

  mdarr_rr_mux #(.AUM(8), .BUM(4), .VUM(4), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .mode      (mode),
    .chan_en   (chan_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] ch, input logic [31:0] d);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".chan"},  32'(out_chan),  32'(ch));
    chk({tag, ".data"},  32'(out_data),  d);
  endtask

  task automatic chk_lvl(input string tag, input int l0, input int l1, input int l2, input int l3);
    chk({tag, ".lvl0"}, 32'(level[0]), 32'(l0));
    chk({tag, ".lvl1"}, 32'(level[1]), 32'(l1));
    chk({tag, ".lvl2"}, 32'(level[2]), 32'(l2));
    chk({tag, ".lvl3"}, 32'(level[3]), 32'(l3));
  endtask

  // Advance one rising edge and land at the following falling edge, then settle.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    mode      = ARB_RR;
    chan_en   = 4'hF;
    in_valid  = 4'h0;
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) in_data[c] = '0;
    tick(); tick(); settle();

    // Reset state
    chk_lvl("rst", 0, 0, 0, 0);
    chk_out("rst", 1'b0, 2'd0, 32'h0);
    rst_n = 1'b1;
    settle();
    chk("rst.in_ready", 32'(in_ready), 32'hF);

    // RR burst: one word on every channel, drained in order 0..3
    out_ready = 1'b1;
    in_valid  = 4'hF;
    for (int c = 0; c < 4; c++) in_data[c] = 32'hA5A5_A5A0 + 32'(c);
    settle();
    chk("rr.nobypass", 32'(out_valid), 32'h0);
    tick(); in_valid = 4'h0; settle();
    chk_lvl("rr.fill", 1, 1, 1, 1);
    chk_out("rr.c0", 1'b1, 2'd0, 32'hA5A5_A5A0);
    tick(); settle(); chk_out("rr.c1", 1'b1, 2'd1, 32'hA5A5_A5A1);
    tick(); settle(); chk_out("rr.c2", 1'b1, 2'd2, 32'hA5A5_A5A2);
    tick(); settle(); chk_out("rr.c3", 1'b1, 2'd3, 32'hA5A5_A5A3);
    tick(); settle();
    chk_out("rr.empty", 1'b0, 2'd0, 32'h0);
    chk("rr.ptr", 32'(dut.rr_ptr_q), 32'h0);

    // Fill ch1 to depth with the output stalled
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid   = 4'b0010;
      in_data[1] = 32'h0000_1000 + 32'(k);
      settle();
      chk("full.ready_before", 32'(in_ready[1]), 32'h1);
      tick();
    end
    settle();
    chk("full.lvl1", 32'(level[1]), 32'h4);
    chk("full.ready", 32'(in_ready[1]), 32'h0);
    in_data[1] = 32'h0000_DEAD;
    tick(); in_valid = 4'h0; settle();
    chk("full.no5th", 32'(level[1]), 32'h4);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk_out("full.drain", 1'b1, 2'd1, 32'h0000_1000 + 32'(k));
      tick();
    end
    settle();
    chk_out("full.empty", 1'b0, 2'd0, 32'h0);
    chk("full.ptr", 32'(dut.rr_ptr_q), 32'h2);

    // Stall on ch2 while toggling chan_en[2] and mode
    out_ready  = 1'b0;
    in_valid   = 4'b0101;
    in_data[0] = 32'h0000_0AAA;
    in_data[2] = 32'h2222_0000;
    tick(); in_valid = 4'h0; settle();
    chk_out("stall.first", 1'b1, 2'd2, 32'h2222_0000);
    tick();
    for (int k = 0; k < 5; k++) begin
      chan_en = k[0] ? 4'hF : 4'b1011;
      mode    = k[0] ? ARB_RR : ARB_FIXED;
      settle();
      chk_out("stall.hold", 1'b1, 2'd2, 32'h2222_0000);
      tick();
    end
    chan_en   = 4'hF;
    mode      = ARB_RR;
    out_ready = 1'b1;
    settle(); chk_out("stall.accept", 1'b1, 2'd2, 32'h2222_0000);
    tick(); settle(); chk_out("stall.next", 1'b1, 2'd0, 32'h0000_0AAA);
    tick(); settle(); chk_out("stall.empty", 1'b0, 2'd0, 32'h0);

    // Fixed priority: ch1 drained fully before ch3
    mode      = ARB_FIXED;
    out_ready = 1'b0;
    in_valid  = 4'b1010;
    in_data[1] = 32'h0000_1100; in_data[3] = 32'h0000_3300;
    tick();
    in_data[1] = 32'h0000_1101; in_data[3] = 32'h0000_3301;
    tick(); in_valid = 4'h0; out_ready = 1'b1; settle();
    chk_out("fix.0", 1'b1, 2'd1, 32'h0000_1100);
    tick(); settle(); chk_out("fix.1", 1'b1, 2'd1, 32'h0000_1101);
    tick(); settle(); chk_out("fix.2", 1'b1, 2'd3, 32'h0000_3300);
    tick(); settle(); chk_out("fix.3", 1'b1, 2'd3, 32'h0000_3301);
    tick(); settle(); chk_out("fix.empty", 1'b0, 2'd0, 32'h0);

    // Simultaneous push and pop at level 3 on ch0
    mode      = ARB_RR;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid   = 4'b0001;
      in_data[0] = 32'h0000_0050 + 32'(k);
      tick();
    end
    settle();
    chk("pp.lvl_before", 32'(level[0]), 32'h3);
    in_data[0] = 32'h0000_0053;
    out_ready  = 1'b1;
    settle(); chk_out("pp.pop", 1'b1, 2'd0, 32'h0000_0050);
    tick(); in_valid = 4'h0; settle();
    chk("pp.lvl_after", 32'(level[0]), 32'h3);
    for (int k = 1; k < 4; k++) begin
      settle();
      chk_out("pp.order", 1'b1, 2'd0, 32'h0000_0050 + 32'(k));
      tick();
    end
    settle(); chk_out("pp.empty", 1'b0, 2'd0, 32'h0);

    // Flush mid-stream
    out_ready = 1'b0;
    in_valid  = 4'hF;
    for (int c = 0; c < 4; c++) in_data[c] = 32'h0000_0F00 + 32'(c);
    tick();
    flush     = 1'b1;
    out_ready = 1'b1;
    settle();
    chk("flush.in_ready", 32'(in_ready), 32'h0);
    tick();
    flush    = 1'b0;
    in_valid = 4'b0100;
    in_data[2] = 32'h0000_0077;
    out_ready  = 1'b0;
    settle();
    chk_lvl("flush.clr", 0, 0, 0, 0);
    chk_out("flush.idle", 1'b0, 2'd0, 32'h0);
    chk("flush.ptr", 32'(dut.rr_ptr_q), 32'h0);
    tick(); in_valid = 4'h0; settle();
    chk_out("flush.first", 1'b1, 2'd2, 32'h0000_0077);

    // Reset mid-stream
    in_valid   = 4'b0010;
    in_data[1] = 32'h0000_0111;
    tick();
    rst_n    = 1'b0;
    in_valid = 4'hF;
    tick();
    rst_n    = 1'b1;
    in_valid = 4'b1000;
    in_data[3] = 32'h0000_0099;
    settle();
    chk_lvl("rst2.clr", 0, 0, 0, 0);
    chk_out("rst2.idle", 1'b0, 2'd0, 32'h0);
    chk("rst2.in_ready", 32'(in_ready), 32'hF);
    tick(); in_valid = 4'h0; settle();
    chk_out("rst2.first", 1'b1, 2'd3, 32'h0000_0099);
    out_ready = 1'b1;
    tick(); settle();
    chk_out("rst2.empty", 1'b0, 2'd0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mdarr_rr_mux
